// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot-time instruction-memory loader
//
// Purpose:
//   Receives a byte stream over a valid/ready handshake, packs bytes into
//   little-endian 32-bit words and writes them to consecutive instruction-
//   memory word addresses. The core is held until loading has completed.
//
// Optional feature (macro LOADER_CKSUM_EN):
//   After the last word, one trailing byte is accepted and compared against
//   the XOR of all data bytes; cksum_err reports a mismatch. When the macro
//   is undefined the CKSUM state is unreachable and cksum_err is tied to 0.
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-low reset
//   start       begin a load (sampled in IDLE and DONE)
//   word_count  number of words to load, clamped to DEPTH
//   rx_valid    rx_data holds a byte
//   rx_data     stream byte
//   rx_ready    loader accepts a byte this cycle
//   imem_we     one-cycle write strobe per word
//   imem_waddr  registered word address of the write
//   imem_wdata  registered assembled word
//   core_hold   1 = core must not advance
//   busy        load in progress
//   done        load complete, held until next start
//   cksum_err   trailing checksum byte mismatch

module program_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              cksum_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    CKSUM = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

`ifdef LOADER_CKSUM_EN
  localparam state_t LOAD_END = CKSUM;
`else
  localparam state_t LOAD_END = DONE;
`endif

  state_t            state;
  state_t            state_n;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   word_idx;
  logic [ADDR_W:0]   word_idx_inc;
  logic [ADDR_W:0]   clamped;
  logic [1:0]        byte_idx;
  logic [23:0]       word_buf;
  logic              load_start;

  assign clamped      = (word_count > DEPTH_C) ? DEPTH_C : word_count;
  assign word_idx_inc = word_idx + 1'b1;
  // A start is honoured only when no load is running.
  assign load_start   = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_n   = state;
    rx_ready  = 1'b0;
    imem_we   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    core_hold = 1'b1;
    case (state)
      IDLE: begin
        if (start) state_n = (clamped == '0) ? LOAD_END : RECV;
      end
      RECV: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid && (byte_idx == 2'd3)) state_n = WRITE;
      end
      WRITE: begin
        imem_we = 1'b1;
        busy    = 1'b1;
        state_n = (word_idx_inc == count) ? LOAD_END : RECV;
      end
      CKSUM: begin
`ifdef LOADER_CKSUM_EN
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_n = DONE;
`else
        state_n = DONE;
`endif
      end
      DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
        if (start) state_n = (clamped == '0) ? LOAD_END : RECV;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      word_idx   <= '0;
      byte_idx   <= 2'd0;
      word_buf   <= 24'd0;
      imem_waddr <= '0;
      imem_wdata <= 32'd0;
    end else begin
      state <= state_n;
      if (load_start) begin
        count    <= clamped;
        word_idx <= '0;
        byte_idx <= 2'd0;
      end
      if ((state == RECV) && rx_valid) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0: word_buf[7:0]   <= rx_data;
          2'd1: word_buf[15:8]  <= rx_data;
          2'd2: word_buf[23:16] <= rx_data;
          default: begin
            // Output registers are loaded here so they are valid during WRITE.
            imem_wdata <= {rx_data, word_buf};
            imem_waddr <= word_idx[ADDR_W-1:0];
          end
        endcase
      end
      if (state == WRITE) word_idx <= word_idx_inc;
    end
  end

`ifdef LOADER_CKSUM_EN
  logic [7:0] acc;
  logic       cksum_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc         <= 8'd0;
      cksum_err_q <= 1'b0;
    end else if (load_start) begin
      acc         <= 8'd0;
      cksum_err_q <= 1'b0;
    end else if ((state == RECV) && rx_valid) begin
      acc <= acc ^ rx_data;
    end else if ((state == CKSUM) && rx_valid) begin
      cksum_err_q <= (rx_data != acc);
    end
  end

  assign cksum_err = cksum_err_q;
`else
  assign cksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader

module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  word_count;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        cksum_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_acc = 0;
  int bad_ready = 0;

  logic [5:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_lat[$];
  logic [7:0]  acc_q[$];

  logic [7:0] s2 [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h52, 8'h00};

`ifdef LOADER_CKSUM_EN
  localparam int CK_BYTES = 1;
`else
  localparam int CK_BYTES = 0;
`endif

  program_loader #(.ADDR_W(6), .DEPTH(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .busy       (busy),
    .done       (done),
    .cksum_err  (cksum_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: logs accepted bytes and write strobes at the falling edge.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      acc_q.push_back(rx_data);
      last_acc <= cyc;
    end
    if (imem_we) begin
      wr_addr.push_back(imem_waddr);
      wr_data.push_back(imem_wdata);
      wr_lat.push_back(cyc - last_acc);
      if (rx_ready) bad_ready <= bad_ready + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      step();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    guard    = 0;
    while (!rx_ready && guard < 50) begin
      step();
      guard++;
    end
    chk("byte_wait", 32'(guard < 50), 32'd1);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic do_start(input logic [6:0] n);
    start      = 1'b1;
    word_count = n;
    step();
    start = 1'b0;
  endtask

  task automatic end_load(input logic [7:0] ck);
`ifdef LOADER_CKSUM_EN
    send_byte(ck, 0);
`else
    if (ck === 8'hxx) rx_data = 8'h00;
    step();
`endif
  endtask

  initial begin
    int base;
    int abase;
    reset      = 1'b1;
    start      = 1'b0;
    word_count = 7'd0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;

    // 1: asynchronous reset mid-cycle with random inputs
    #13;
    start      = 1'($urandom);
    rx_valid   = 1'($urandom);
    rx_data    = 8'($urandom);
    word_count = 7'($urandom);
    reset      = 1'b0;
    #1;
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_waddr", 32'(imem_waddr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_core_hold", 32'(core_hold), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cksum_err", 32'(cksum_err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      start    = 1'($urandom);
      rx_valid = 1'($urandom);
      rx_data  = 8'($urandom);
    end
    chk("rst_hold_busy", 32'(busy), 32'd0);
    chk("rst_no_writes", 32'(wr_addr.size()), 32'd0);
    start    = 1'b0;
    rx_valid = 1'b0;
    reset    = 1'b1;
    step();
    chk("idle_rx_ready", 32'(rx_ready), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    // 2: two-word load, back-to-back bytes
    base = wr_addr.size();
    do_start(7'd2);
    chk("s2_busy", 32'(busy), 32'd1);
    chk("s2_rx_ready", 32'(rx_ready), 32'd1);
    chk("s2_hold", 32'(core_hold), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(s2[i], 0);
    chk("s2_we_now", 32'(imem_we), 32'd1);
    chk("s2_addr_now", 32'(imem_waddr), 32'd1);
    chk("s2_ready_in_write", 32'(rx_ready), 32'd0);
    end_load(8'hF2);
    chk("s2_done", 32'(done), 32'd1);
    chk("s2_core_hold", 32'(core_hold), 32'd0);
    chk("s2_busy_end", 32'(busy), 32'd0);
    chk("s2_cksum_err", 32'(cksum_err), 32'd0);
    chk("s2_nwr", 32'(wr_addr.size() - base), 32'd2);
    if (wr_addr.size() >= base + 2) begin
      chk("s2_addr0", 32'(wr_addr[base]), 32'd0);
      chk("s2_data0", wr_data[base], 32'h0000_0013);
      chk("s2_lat0", 32'(wr_lat[base]), 32'd1);
      chk("s2_addr1", 32'(wr_addr[base+1]), 32'd1);
      chk("s2_data1", wr_data[base+1], 32'h0052_00B3);
      chk("s2_lat1", 32'(wr_lat[base+1]), 32'd1);
    end
    step();
    chk("s2_done_held", 32'(done), 32'd1);

    // 3: restart from DONE with gaps; start held during the load is ignored
    base  = wr_addr.size();
    abase = acc_q.size();
    do_start(7'd2);
    chk("s3_done_cleared", 32'(done), 32'd0);
    chk("s3_hold", 32'(core_hold), 32'd1);
    start      = 1'b1;
    word_count = 7'd7;
    for (int i = 0; i < 8; i++) send_byte(s2[i], int'($urandom_range(0, 2)));
    start = 1'b0;
    end_load(8'hF2);
    chk("s3_done", 32'(done), 32'd1);
    chk("s3_nwr", 32'(wr_addr.size() - base), 32'd2);
    if (wr_addr.size() >= base + 2) begin
      chk("s3_addr0", 32'(wr_addr[base]), 32'd0);
      chk("s3_data0", wr_data[base], 32'h0000_0013);
      chk("s3_addr1", 32'(wr_addr[base+1]), 32'd1);
      chk("s3_data1", wr_data[base+1], 32'h0052_00B3);
    end
    chk("s3_nbytes", 32'(acc_q.size() - abase), 32'(8 + CK_BYTES));
    for (int i = 0; i < 8; i++)
      if (acc_q.size() > abase + i) chk("s3_byte", 32'(acc_q[abase+i]), 32'(s2[i]));
    chk("s3_ready_in_write", 32'(bad_ready), 32'd0);

    // 4: reset after two bytes of word 1
    base = wr_addr.size();
    do_start(7'd2);
    for (int i = 0; i < 6; i++) send_byte(s2[i], 0);
    #1;
    reset = 1'b0;
    #1;
    chk("s4_busy", 32'(busy), 32'd0);
    chk("s4_hold", 32'(core_hold), 32'd1);
    chk("s4_rx_ready", 32'(rx_ready), 32'd0);
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data = 8'($urandom);
      step();
    end
    rx_valid = 1'b0;
    reset    = 1'b1;
    step();
    chk("s4_nwr", 32'(wr_addr.size() - base), 32'd1);
    chk("s4_done", 32'(done), 32'd0);
    chk("s4_hold_after", 32'(core_hold), 32'd1);
    chk("s4_idle_busy", 32'(busy), 32'd0);

    // 5a: zero words
    base = wr_addr.size();
    do_start(7'd0);
`ifdef LOADER_CKSUM_EN
    send_byte(8'h00, 0);
`endif
    chk("s5_zero_done", 32'(done), 32'd1);
    chk("s5_zero_nwr", 32'(wr_addr.size() - base), 32'd0);

    // 5b: 80 requested, clamped to 64
    base = wr_addr.size();
    do_start(7'd80);
    for (int i = 0; i < 256; i++) send_byte(8'(i), 0);
    end_load(8'h00);
    chk("s5_clamp_done", 32'(done), 32'd1);
    chk("s5_clamp_nwr", 32'(wr_addr.size() - base), 32'd64);
    if (wr_addr.size() >= base + 64) begin
      chk("s5_first_data", wr_data[base], 32'h0302_0100);
      chk("s5_last_addr", 32'(wr_addr[base+63]), 32'd63);
      chk("s5_last_data", wr_data[base+63], 32'hFFFE_FDFC);
    end
    step();
    chk("s5_no_extra_wr", 32'(wr_addr.size() - base), 32'd64);

`ifdef LOADER_CKSUM_EN
    // 6: wrong trailing checksum byte
    do_start(7'd2);
    for (int i = 0; i < 8; i++) send_byte(s2[i], 0);
    end_load(8'h00);
    chk("s6_cksum_err", 32'(cksum_err), 32'd1);
    chk("s6_done", 32'(done), 32'd1);
    chk("s6_hold", 32'(core_hold), 32'd0);
    do_start(7'd0);
    chk("s6_err_cleared", 32'(cksum_err), 32'd0);
    send_byte(8'h00, 0);
    chk("s6_zero_ok", 32'(cksum_err), 32'd0);
`else
    chk("s6_err_tied", 32'(cksum_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
